cam_ctrl: RTL and testbench

Sequencing and arbitration controller for the 256 × 16 content-addressable memory. It shares the CAM between a lookup requester and an update (insert/delete) requester using round-robin arbitration. It keeps a valid bitmap and allocates free slots, and it de-duplicates inserts by searching before writing. After reset it clears the CAM by writing a reserved null key to every entry, so stale contents can never produce a hit.

---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_free_enc.sv | 25 ++
 rtl/cam_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants, encodings and state type for the CAM sequencing controller
package cam_pkg;

  localparam int CAM_KEY_W = 16;
  localparam int CAM_DEPTH = 256;
  localparam int CAM_AW    = 8;
  localparam logic [CAM_KEY_W-1:0] CAM_KEY_NULL = 16'hFFFF;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  typedef enum logic [1:0] {
    STAT_OK   = 2'b00,
    STAT_DUP  = 2'b01,
    STAT_FULL = 2'b10,
    STAT_BAD  = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SEARCH,
    S_RESOLVE,
    S_WRITE,
    S_ACK
  } state_e;

endpackage

// File: rtl/cam_free_enc.sv
// rtl/cam_free_enc.sv - lowest-free-slot priority encoder over the valid bitmap
module cam_free_enc
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH,
  parameter int AW    = CAM_AW
) (
  input  logic [DEPTH-1:0] valid_i,
  output logic [AW-1:0]    free_idx_o,
  output logic             full_o
);

  // Scan from the top down so the last assignment wins with the lowest zero.
  always_comb begin
    free_idx_o = '0;
    full_o     = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_idx_o = AW'(i);
        full_o     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - round-robin lookup/update sequencer for a 256x16 CAM with slot allocation and clear sweep
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int KEY_W = CAM_KEY_W,
  parameter int DEPTH = CAM_DEPTH,
  parameter logic [KEY_W-1:0] KEY_NULL = CAM_KEY_NULL,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l_req,
  input  logic [KEY_W-1:0] l_key,
  output logic             l_ack,
  output logic             l_hit,
  output logic [AW-1:0]    l_addr,
  input  logic             u_req,
  input  logic             u_op,
  input  logic [KEY_W-1:0] u_key,
  input  logic [AW-1:0]    u_addr,
  output logic             u_ack,
  output logic [1:0]       u_status,
  output logic [AW-1:0]    u_res_addr,
  output logic             init_done,
  output logic [AW:0]      count,
  output logic             cam_enable,
  output logic             cam_match_en,
  output logic             cam_write_en,
  output logic [KEY_W-1:0] cam_data,
  output logic [AW-1:0]    cam_write_addr,
  input  logic             cam_match,
  input  logic [AW-1:0]    cam_match_addr
);

  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] SWEEP_END = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    sweep_q, sweep_d;
  logic             init_done_q, init_done_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW:0]      count_q, count_d;
  logic             prio_u_q, prio_u_d;
  logic             upd_q, upd_d;
  logic             op_q, op_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             hit_q, hit_d;
  logic [AW-1:0]    laddr_q, laddr_d;
  status_e          status_q, status_d;
  logic [AW-1:0]    res_addr_q, res_addr_d;

  logic [AW-1:0]    free_idx;
  logic             free_full;

  cam_free_enc #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_free_enc (
    .valid_i    (valid_q),
    .free_idx_o (free_idx),
    .full_o     (free_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      valid_q     <= '0;
      count_q     <= '0;
      prio_u_q    <= 1'b0;
      upd_q       <= 1'b0;
      op_q        <= OP_INSERT;
      key_q       <= '0;
      addr_q      <= '0;
      hit_q       <= 1'b0;
      laddr_q     <= '0;
      status_q    <= STAT_OK;
      res_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      prio_u_q    <= prio_u_d;
      upd_q       <= upd_d;
      op_q        <= op_d;
      key_q       <= key_d;
      addr_q      <= addr_d;
      hit_q       <= hit_d;
      laddr_q     <= laddr_d;
      status_q    <= status_d;
      res_addr_q  <= res_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    init_done_d    = init_done_q;
    valid_d        = valid_q;
    count_d        = count_q;
    prio_u_d       = prio_u_q;
    upd_d          = upd_q;
    op_d           = op_q;
    key_d          = key_q;
    addr_d         = addr_q;
    hit_d          = hit_q;
    laddr_d        = laddr_q;
    status_d       = status_q;
    res_addr_d     = res_addr_q;
    cam_enable     = 1'b1;
    cam_match_en   = 1'b0;
    cam_write_en   = 1'b0;
    cam_data       = key_q;
    cam_write_addr = addr_q;
    l_ack          = 1'b0;
    u_ack          = 1'b0;

    case (state_q)
      S_INIT: begin
        cam_write_en   = 1'b1;
        cam_data       = KEY_NULL;
        cam_write_addr = sweep_q;
        sweep_d        = sweep_q + AW'(1);
        if (sweep_q == SWEEP_END) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end

      S_IDLE: begin
        // prio_u_q set means lookup won last time, so update goes first on contention.
        if (l_req && (!u_req || !prio_u_q)) begin
          upd_d    = 1'b0;
          prio_u_d = 1'b1;
          key_d    = l_key;
          if (l_key == KEY_NULL) begin
            hit_d   = 1'b0;
            laddr_d = '0;
            state_d = S_ACK;
          end else begin
            state_d = S_SEARCH;
          end
        end else if (u_req) begin
          upd_d      = 1'b1;
          prio_u_d   = 1'b0;
          op_d       = u_op;
          key_d      = u_key;
          addr_d     = u_addr;
          res_addr_d = '0;
          if (u_op == OP_INSERT) begin
            if (u_key == KEY_NULL) begin
              status_d = STAT_BAD;
              state_d  = S_ACK;
            end else begin
              state_d = S_SEARCH;
            end
          end else if (valid_q[u_addr]) begin
            state_d = S_WRITE;
          end else begin
            status_d = STAT_BAD;
            state_d  = S_ACK;
          end
        end
      end

      S_SEARCH: begin
        cam_match_en = 1'b1;
        cam_data     = key_q;
        state_d      = S_RESOLVE;
      end

      S_RESOLVE: begin
        state_d = S_ACK;
        if (!upd_q) begin
          hit_d   = cam_match && valid_q[cam_match_addr];
          laddr_d = (cam_match && valid_q[cam_match_addr]) ? cam_match_addr : '0;
        end else if (cam_match) begin
          status_d   = STAT_DUP;
          res_addr_d = cam_match_addr;
        end else if (count_q == CNT_FULL || free_full) begin
          status_d = STAT_FULL;
        end else begin
          addr_d  = free_idx;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        cam_write_en   = 1'b1;
        cam_write_addr = addr_q;
        status_d       = STAT_OK;
        state_d        = S_ACK;
        if (op_q == OP_INSERT) begin
          cam_data         = key_q;
          valid_d[addr_q]  = 1'b1;
          count_d          = count_q + (AW+1)'(1);
          res_addr_d       = addr_q;
        end else begin
          cam_data         = KEY_NULL;
          valid_d[addr_q]  = 1'b0;
          count_d          = count_q - (AW+1)'(1);
          res_addr_d       = '0;
        end
      end

      S_ACK: begin
        l_ack   = !upd_q;
        u_ack   = upd_q;
        state_d = S_IDLE;
      end

      default: state_d = S_INIT;
    endcase

    // Keep the CAM quiet while reset is held so an aborted write never lands.
    if (rst) begin
      cam_enable   = 1'b0;
      cam_match_en = 1'b0;
      cam_write_en = 1'b0;
      l_ack        = 1'b0;
      u_ack        = 1'b0;
    end
  end

  assign l_hit      = hit_q;
  assign l_addr     = laddr_q;
  assign u_status   = status_q;
  assign u_res_addr = res_addr_q;
  assign init_done  = init_done_q;
  assign count      = count_q;

  // Invalid slots always hold KEY_NULL, which is never searched for.
  a_lookup_hit_valid: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_RESOLVE && !upd_q && cam_match) |-> valid_q[cam_match_addr]);

endmodule

// File: tb/tb_cam_ctrl.sv
// tb/tb_cam_ctrl.sv - randomized self-checking bench for cam_ctrl with a behavioural CAM and table model
module tb_cam_ctrl;
  import cam_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        l_req, l_ack, l_hit;
  logic [15:0] l_key;
  logic [7:0]  l_addr;
  logic        u_req, u_op, u_ack;
  logic [15:0] u_key;
  logic [7:0]  u_addr, u_res_addr;
  logic [1:0]  u_status;
  logic        init_done;
  logic [8:0]  count;
  logic        cam_enable, cam_match_en, cam_write_en;
  logic [15:0] cam_data;
  logic [7:0]  cam_write_addr;
  logic        cam_match;
  logic [7:0]  cam_match_addr;

  always #5 clk = ~clk;

  cam_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .l_req          (l_req),
    .l_key          (l_key),
    .l_ack          (l_ack),
    .l_hit          (l_hit),
    .l_addr         (l_addr),
    .u_req          (u_req),
    .u_op           (u_op),
    .u_key          (u_key),
    .u_addr         (u_addr),
    .u_ack          (u_ack),
    .u_status       (u_status),
    .u_res_addr     (u_res_addr),
    .init_done      (init_done),
    .count          (count),
    .cam_enable     (cam_enable),
    .cam_match_en   (cam_match_en),
    .cam_write_en   (cam_write_en),
    .cam_data       (cam_data),
    .cam_write_addr (cam_write_addr),
    .cam_match      (cam_match),
    .cam_match_addr (cam_match_addr)
  );

  // Behavioural CAM: registered match flag and lowest matching address.
  logic [15:0] cam_mem [256];
  logic        cam_scramble;

  function automatic logic cam_hit_f(input logic [15:0] k);
    for (int i = 0; i < 256; i++) if (cam_mem[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] cam_addr_f(input logic [15:0] k);
    for (int i = 0; i < 256; i++) if (cam_mem[i] == k) return 8'(i);
    return 8'd0;
  endfunction

  always @(posedge clk) begin
    if (cam_scramble) begin
      for (int i = 0; i < 256; i++)
        cam_mem[i] <= (i == 7) ? 16'h1234 : ((i == 9) ? 16'hABCD : 16'($urandom));
      cam_match      <= 1'b0;
      cam_match_addr <= 8'd0;
    end else if (cam_enable) begin
      if (cam_write_en) cam_mem[cam_write_addr] <= cam_data;
      if (cam_match_en) begin
        cam_match      <= cam_hit_f(cam_data);
        cam_match_addr <= cam_addr_f(cam_data);
      end
    end
  end

  int excl_viol = 0;
  always @(negedge clk) if (cam_match_en && cam_write_en) excl_viol <= excl_viol + 1;

  // Reference table: what each slot holds and whether it is allocated.
  logic [15:0] mdl_key [256];
  bit          mdl_valid [256];
  int          mdl_count;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 256; i++) begin
      mdl_valid[i] = 1'b0;
      mdl_key[i]   = 16'h0;
    end
    mdl_count = 0;
  endtask

  function automatic int mdl_find(input logic [15:0] k);
    for (int i = 0; i < 256; i++) if (mdl_valid[i] && mdl_key[i] == k) return i;
    return -1;
  endfunction

  function automatic int mdl_free();
    for (int i = 0; i < 256; i++) if (!mdl_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] new_key();
    logic [15:0] k;
    do k = 16'($urandom); while (k == 16'hFFFF || k == 16'hABCD || mdl_find(k) >= 0);
    return k;
  endfunction

  function automatic int rand_valid();
    int i;
    do i = $urandom_range(0, 255); while (!mdl_valid[i]);
    return i;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_cam_ctl", 32'({cam_enable, cam_write_en, cam_match_en}), 32'd0);
    check_val("rst_acks", 32'({l_ack, u_ack}), 32'd0);
    check_val("rst_results", 32'({l_hit, l_addr, u_status, u_res_addr}), 32'd0);
    check_val("rst_done_cnt", 32'({init_done, count}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_init();
    int bad_ctl = 0, bad_data = 0, bad_addr = 0, early = 0, acks = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!(cam_enable && cam_write_en && !cam_match_en)) bad_ctl++;
      if (cam_data !== 16'hFFFF) bad_data++;
      if (cam_write_addr !== 8'(i)) bad_addr++;
      if (init_done) early++;
      if (l_ack || u_ack) acks++;
    end
    @(negedge clk);
    check_val("init_ctl", bad_ctl, 0);
    check_val("init_data", bad_data, 0);
    check_val("init_addr", bad_addr, 0);
    check_val("init_early_done", early, 0);
    check_val("init_acks", acks, 0);
    check_val("init_done", 32'(init_done), 32'd1);
    check_val("init_we_off", 32'(cam_write_en), 32'd0);
    check_val("init_count", 32'(count), 32'd0);
  endtask

  task automatic lookup(input logic [15:0] key);
    int exp_idx, exp_lat, lat;
    exp_idx = (key == 16'hFFFF) ? -1 : mdl_find(key);
    exp_lat = (key == 16'hFFFF) ? 1 : 3;
    @(negedge clk);
    l_key = key;
    l_req = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!l_ack && lat < 40);
    l_req = 1'b0;
    check_val("lk_lat", lat, exp_lat);
    check_val("lk_hit", 32'(l_hit), 32'(exp_idx >= 0));
    check_val("lk_addr", 32'(l_addr), (exp_idx >= 0) ? exp_idx : 0);
  endtask

  task automatic update(input logic op, input logic [15:0] key, input logic [7:0] addr,
                        output logic [7:0] res);
    int exp_st, exp_res, exp_lat, idx, lat;
    exp_res = 0;
    if (op == OP_DELETE) begin
      if (mdl_valid[addr]) begin
        exp_st = 0; exp_lat = 2;
        mdl_valid[addr] = 1'b0;
        mdl_count--;
      end else begin
        exp_st = 3; exp_lat = 1;
      end
    end else if (key == 16'hFFFF) begin
      exp_st = 3; exp_lat = 1;
    end else begin
      idx = mdl_find(key);
      if (idx >= 0) begin
        exp_st = 1; exp_res = idx; exp_lat = 3;
      end else if (mdl_count == 256) begin
        exp_st = 2; exp_lat = 3;
      end else begin
        idx = mdl_free();
        exp_st = 0; exp_res = idx; exp_lat = 4;
        mdl_valid[idx] = 1'b1;
        mdl_key[idx]   = key;
        mdl_count++;
      end
    end
    @(negedge clk);
    u_op = op; u_key = key; u_addr = addr; u_req = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!u_ack && lat < 40);
    u_req = 1'b0;
    res = u_res_addr;
    check_val("upd_lat", lat, exp_lat);
    check_val("upd_status", 32'(u_status), exp_st);
    check_val("upd_res_addr", 32'(u_res_addr), exp_res);
    check_val("upd_count", 32'(count), mdl_count);
  endtask

  initial begin
    logic [15:0] k;
    logic [7:0]  res;
    int          r, n, cyc;

    rst = 1'b1; cam_scramble = 1'b1;
    l_req = 1'b0; l_key = 16'h0;
    u_req = 1'b0; u_op = 1'b0; u_key = 16'h0; u_addr = 8'h0;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1 cam_scramble = 1'b0;

    reset_dut();
    check_init();

    // Stale CAM contents (1234 at 7, ABCD at 9) must have been swept away.
    lookup(16'hABCD);
    update(OP_INSERT, 16'h1234, 8'd0, res);
    check_val("ins1234_addr", 32'(res), 32'd0);
    update(OP_INSERT, 16'h1234, 8'd0, res);
    check_val("dup1234_addr", 32'(res), 32'd0);
    lookup(16'h1234);

    n = 0;
    while (mdl_count < 256) begin
      k = (mdl_free() == 5) ? 16'hABCD : new_key();
      update(OP_INSERT, k, 8'd0, res);
      n++;
      if (n % 16 == 0) lookup(mdl_key[rand_valid()]);
    end
    check_val("fill_count", 32'(count), 32'd256);
    update(OP_INSERT, new_key(), 8'd0, res);
    update(OP_DELETE, 16'h0, 8'd17, res);
    update(OP_INSERT, new_key(), 8'd0, res);
    check_val("reuse17_addr", 32'(res), 32'd17);

    update(OP_DELETE, 16'h0, 8'd5, res);
    lookup(16'hABCD);
    update(OP_DELETE, 16'h0, 8'd5, res);
    update(OP_INSERT, 16'hFFFF, 8'd0, res);
    lookup(16'hFFFF);

    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: lookup((mdl_count > 0) ? mdl_key[rand_valid()] : new_key());
        1: lookup(new_key());
        2: begin
          k = new_key();
          update(OP_INSERT, k, 8'd0, res);
          lookup(k);
        end
        3: update(OP_INSERT, (mdl_count > 0) ? mdl_key[rand_valid()] : new_key(), 8'd0, res);
        default: update(OP_DELETE, 16'h0, 8'($urandom), res);
      endcase
    end

    if (mdl_count == 256) update(OP_DELETE, 16'h0, 8'd0, res);
    k = new_key();
    @(negedge clk);
    u_op = OP_INSERT; u_key = k; u_addr = 8'd0; u_req = 1'b1;
    repeat (3) @(negedge clk);
    check_val("mid_write_en", 32'(cam_write_en), 32'd1);
    check_val("mid_no_ack", 32'(u_ack), 32'd0);
    rst = 1'b1;
    u_req = 1'b0;
    @(negedge clk);
    check_val("mid_rst_ack", 32'(u_ack), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mdl_clear();
    check_init();
    lookup(k);

    reset_dut();
    check_init();
    @(negedge clk);
    l_key = new_key(); u_op = OP_INSERT; u_key = 16'hFFFF;
    l_req = 1'b1; u_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (l_ack || u_ack) begin
        check_val("arb_port", 32'(u_ack), 32'(n % 2));
        check_val("arb_single", 32'(l_ack && u_ack), 32'd0);
        if (l_ack) check_val("arb_lk_hit", 32'(l_hit), 32'd0);
        else       check_val("arb_upd_status", 32'(u_status), 32'd3);
        n++;
      end
    end
    l_req = 1'b0; u_req = 1'b0;
    check_val("arb_acks", n, 8);

    repeat (2) @(negedge clk);
    check_val("match_write_excl", excl_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
